// File: rtl/sub8_serial.sv
// sub8_serial: bit-serial subtractor, diff = a - b - bin, one bit per clock, LSB first.
// A start in IDLE or DONE captures the operands. WIDTH RUN cycles follow, then one DONE
// cycle that loads the result registers. done, diff and the flags show up one cycle later.
module sub8_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d, b_sr_q, b_sr_d, res_q, res_d;
  logic             brw_q, brw_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             amsb_q, amsb_d, bmsb_q, bmsb_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d, zero_q, zero_d, neg_q, neg_d, ovf_q, ovf_d;
  logic             capture, dbit;

  // Next-state, datapath step and output-register loading.
  always_comb begin
    state_d = state_q;
    a_sr_d  = a_sr_q;
    b_sr_d  = b_sr_q;
    res_d   = res_q;
    brw_d   = brw_q;
    cnt_d   = cnt_q;
    amsb_d  = amsb_q;
    bmsb_d  = bmsb_q;
    done_d  = 1'b0;
    diff_d  = diff_q;
    bout_d  = bout_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;
    capture = 1'b0;
    dbit    = a_sr_q[0] ^ b_sr_q[0] ^ brw_q;

    case (state_q)
      IDLE: begin
        if (start) capture = 1'b1;
      end
      RUN: begin
        res_d  = {dbit, res_q[WIDTH-1:1]};
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        brw_d  = (~a_sr_q[0] & b_sr_q[0]) | (~(a_sr_q[0] ^ b_sr_q[0]) & brw_q);
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = DONE;
      end
      DONE: begin
        // The result register is complete now. Publish it and the flags on this edge.
        done_d = 1'b1;
        diff_d = res_q;
        bout_d = brw_q;
        zero_d = (res_q == '0);
        neg_d  = res_q[WIDTH-1];
        ovf_d  = (amsb_q != bmsb_q) && (res_q[WIDTH-1] != amsb_q);
        if (start) capture = 1'b1;
        else       state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (capture) begin
      a_sr_d  = a;
      b_sr_d  = b;
      brw_d   = bin;
      res_d   = '0;
      cnt_d   = '0;
      amsb_d  = a[WIDTH-1];
      bmsb_d  = b[WIDTH-1];
      state_d = RUN;
    end

    busy_d = (state_d == RUN);
  end

  // State and registered outputs. Reset takes priority, so a start in the reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      res_q   <= '0;
      brw_q   <= 1'b0;
      cnt_q   <= '0;
      amsb_q  <= 1'b0;
      bmsb_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      res_q   <= res_d;
      brw_q   <= brw_d;
      cnt_q   <= cnt_d;
      amsb_q  <= amsb_d;
      bmsb_q  <= bmsb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
  assign zero = zero_q;
  assign neg  = neg_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_sub8_serial.sv
// Bench for sub8_serial. A timing and arithmetic model is checked against the DUT on every
// cycle. Directed cases with hand-computed literal results pin down the model.
module tb_sub8_serial;
  localparam int W = 8;

  logic         clk = 1'b0, rst = 1'b1, start = 1'b0, bin = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, bout, zero, neg, ovf;
  logic [W-1:0] diff;

  int nchk = 0, nerr = 0, cyc = 0;

  sub8_serial #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout), .zero(zero), .neg(neg), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Result bundle {ovf, neg, zero, bout, diff}, computed with plain wide arithmetic.
  function automatic logic [W+3:0] ref_res(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c);
    logic [W:0]   t;
    logic [W-1:0] d;
    t = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, c};
    d = t[W-1:0];
    return {(x[W-1] != y[W-1]) && (d[W-1] != x[W-1]), d[W-1], d == '0, t[W], d};
  endfunction

  // Model. A start is accepted when no operation is in flight or its done edge has come.
  // The done pulse and the new result appear W+1 edges after capture. busy is high for
  // the W cycles after capture.
  logic         pend = 1'b0, m_busy = 1'b0, m_done = 1'b0;
  logic [W+3:0] m_res = '0, pend_res = '0;
  int           cap_at = 0, done_at = 0, free_at = 0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      pend = 1'b0; m_busy = 1'b0; m_done = 1'b0; m_res = '0; free_at = cyc + 1;
    end else begin
      m_done = 1'b0;
      if (pend && cyc == done_at) begin
        m_done = 1'b1; m_res = pend_res; pend = 1'b0;
      end
      if (start && cyc >= free_at) begin
        pend = 1'b1; cap_at = cyc; done_at = cyc + W + 1; free_at = done_at;
        pend_res = ref_res(a, b, bin);
      end
      m_busy = pend && (cyc < cap_at + W);
    end
  end

  // Compare the DUT with the model on every cycle.
  always @(posedge clk) begin
    #1;
    chk("outs", {busy, done, ovf, neg, zero, bout, diff}, {m_busy, m_done, m_res});
  end

  task automatic wait_done(input string nm, input int cap);
    int n;
    n = 0;
    while (!done && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_lat"}, cyc - cap, W + 1);
  endtask

  task automatic op(input logic [7:0] ia, input logic [7:0] ib, input logic ibin,
                    input logic [7:0] ed, input logic eb, input logic ez,
                    input logic en, input logic eo);
    int cap;
    @(negedge clk);
    a = ia; b = ib; bin = ibin; start = 1'b1;
    @(negedge clk);
    start = 1'b0; cap = cyc;
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    wait_done("op", cap);
    chk("op_diff", diff, ed);
    chk("op_flags", {bout, zero, neg, ovf}, {eb, ez, en, eo});
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom % 6)
      0: return 8'h00;
      1: return 8'hFF;
      2: return 8'h80;
      3: return 8'h7F;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    int cap, last, npul;
    repeat (2) @(negedge clk);
    chk("reset_outs", {busy, done, diff, bout, zero, neg, ovf}, '0);
    rst = 1'b0;

    op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
    op(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b1, 1'b0);
    op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1);
    op(8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    op(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0);
    op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0);

    // A start pulse in the 3rd RUN cycle is ignored.
    @(negedge clk);
    a = 8'h40; b = 8'h01; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; cap = cyc;
    repeat (2) @(negedge clk);
    a = 8'h99; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ign", cap);
    chk("ign_diff", diff, 8'h3F);

    // Reset in the 5th RUN cycle aborts the operation. A start in the same cycle is dropped.
    @(negedge clk);
    a = 8'h33; b = 8'h11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rst_outs", {busy, done, diff, bout, zero, neg, ovf}, '0);
    repeat (14) begin
      @(negedge clk);
      chk("rst_nodone", done, 1'b0);
    end
    op(8'h33, 8'h11, 1'b0, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0);

    // Holding start high restarts the operation in every DONE cycle.
    @(negedge clk);
    a = 8'h0A; b = 8'h04; bin = 1'b0; start = 1'b1;
    last = -1; npul = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) begin
        chk("cont_diff", diff, 8'h06);
        if (last >= 0) chk("cont_gap", cyc - last, W + 1);
        last = cyc; npul++;
      end
    end
    start = 1'b0;
    chk("cont_pulses", npul, 4);
    repeat (12) @(negedge clk);

    // Streaming with random operands that change every cycle.
    start = 1'b1;
    repeat (900) begin
      @(negedge clk);
      a = pick(); b = pick(); bin = 1'($urandom);
    end
    // Random start, operand and rare reset traffic.
    repeat (3000) begin
      @(negedge clk);
      start = ($urandom % 4) != 0;
      a = pick(); b = pick(); bin = 1'($urandom);
      rst = ($urandom % 200) == 0;
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    repeat (12) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
